// File: rtl/dmem_sync.sv
// dmem_sync: word-organised data memory with synchronous read, per-byte
// write lanes, a valid/ready request channel, fixed-latency responses and
// an optional post-reset zeroing sweep.

// One byte lane of the storage array; all four lanes share address/strobe.
module dmem_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  // Single-port byte RAM: write and registered read share the address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

module dmem_sync #(
  parameter int ADDR_WIDTH     = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  init_done
);
  localparam int WORD_W = ADDR_WIDTH - 2;
  localparam int DEPTH  = 1 << WORD_W;

  typedef enum logic {CLEAR, RUN} state_t;

  // Request attributes carried alongside the read word to the formatter.
  typedef struct packed {
    logic       write;
    logic       err;
    logic [2:0] f3;
    logic [1:0] off;
  } meta_t;

  state_t                state;
  logic [WORD_W-1:0]     cnt;
  logic                  ready_q;
  logic                  acc;
  logic                  legal;
  logic [1:0]            off;
  logic [3:0]            be;
  logic [3:0][7:0]       wword;
  logic [3:0]            arr_we;
  logic                  arr_re;
  logic [WORD_W-1:0]     arr_addr;
  logic [3:0][7:0]       arr_wdata;
  logic [3:0][7:0]       rword;
  meta_t                 meta1;
  logic [31:0]           d1;
  logic [31:0]           data_out;
  logic                  err_out;
  logic [READ_LATENCY:1] vld_pipe;

  assign off       = req_addr[1:0];
  assign req_ready = ready_q;
  assign init_done = ready_q;
  // Reset is sampled at the edge, so a request coinciding with it is ignored.
  assign acc       = req_valid && ready_q && !reset;

  // Sweep/run FSM; ready is registered so it is low throughout reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == WORD_W'(DEPTH - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Legality, lane enables and replicated store data from funct3/offset.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b100:  legal = !req_write;
      3'b001:  legal = !off[0];
      3'b101:  legal = !req_write && !off[0];
      3'b010:  legal = (off == 2'b00);
      default: legal = 1'b0;
    endcase
    be    = '0;
    wword = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin be = 4'b0001 << off; wword = {4{req_wdata[7:0]}};  end
      2'b01: begin be = 4'b0011 << off; wword = {2{req_wdata[15:0]}}; end
      2'b10: be = 4'b1111;
      default: be = '0;
    endcase
    if (!legal) be = '0;
  end

  // Array port mux: the sweep owns the port while clearing.
  always_comb begin
    arr_we    = '0;
    arr_re    = 1'b0;
    arr_addr  = req_addr[ADDR_WIDTH-1:2];
    arr_wdata = wword;
    if (state == CLEAR && !reset) begin
      arr_we    = '1;
      arr_addr  = cnt;
      arr_wdata = '0;
    end else if (acc) begin
      arr_we = req_write ? be : 4'b0000;
      arr_re = !req_write;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dmem_lane #(.AW(WORD_W)) u_lane (
      .clk   (clk),
      .we    (arr_we[g]),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata[g]),
      .rdata (rword[g])
    );
  end

  // Capture request attributes at the accept edge, beside the RAM read.
  always_ff @(posedge clk) begin
    if (acc) meta1 <= '{write: req_write, err: !legal, f3: req_funct3, off: off};
  end

  // Response valid shift register; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Lane select and sign/zero extension of the read word.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b  = rword[meta1.off];
    h  = meta1.off[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};
    d1 = '0;
    case (meta1.f3)
      3'b000:  d1 = {{24{b[7]}}, b};
      3'b100:  d1 = {24'h0, b};
      3'b001:  d1 = {{16{h[15]}}, h};
      3'b101:  d1 = {16'h0, h};
      3'b010:  d1 = rword;
      default: d1 = '0;
    endcase
    if (meta1.write || meta1.err) d1 = '0;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign data_out = d1;
    assign err_out  = meta1.err;
  end else begin : g_lat2
    logic [31:0] data2;
    logic        err2;
    // Extra output register stage for the longer-latency configuration.
    always_ff @(posedge clk) begin
      if (reset) begin
        data2 <= '0;
        err2  <= 1'b0;
      end else begin
        data2 <= d1;
        err2  <= meta1.err;
      end
    end
    assign data_out = data2;
    assign err_out  = err2;
  end

  assign rsp_valid = vld_pipe[READ_LATENCY];
  assign rsp_data  = rsp_valid ? data_out : 32'h0;
  assign rsp_err   = rsp_valid && err_out;
endmodule

// File: tb/tb_dmem_sync.sv
// Directed bench: two instances share the request stimulus.
// u1: ADDR_WIDTH=6, READ_LATENCY=1; u2: ADDR_WIDTH=7, READ_LATENCY=2.
module tb_dmem_sync;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rdy1, rv1, re1, id1, rdy2, rv2, re2, id2;
  logic [31:0] rd1, rd2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_sync #(.ADDR_WIDTH(6), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr[5:0]),
    .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1),
    .init_done(id1));

  dmem_sync #(.ADDR_WIDTH(7), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv2), .rsp_data(rd2), .rsp_err(re2),
    .init_done(id2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; u1 responds after the accept edge, u2 one edge later.
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [6:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".v1"}, rv1, 1'b1); chk({tag, ".d1"}, rd1, exp_d); chk({tag, ".e1"}, re1, exp_e);
    @(posedge clk); #1;
    chk({tag, ".v2"}, rv2, 1'b1); chk({tag, ".d2"}, rd2, exp_d); chk({tag, ".e2"}, re2, exp_e);
    chk({tag, ".v1off"}, rv1, 1'b0);
  endtask

  // Called at posedge+1 with reset low; u1 clears 16 words, u2 clears 32.
  task automatic wait_clear(input string tag);
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk); #1;
      chk({tag, ".rdy1"}, rdy1, i >= 16);
      chk({tag, ".rdy2"}, rdy2, i >= 32);
    end
    chk({tag, ".id1"}, id1, 1'b1);
    chk({tag, ".id2"}, id2, 1'b1);
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst.rdy1", rdy1, 1'b0); chk("rst.rdy2", rdy2, 1'b0);
    chk("rst.rv1", rv1, 1'b0);   chk("rst.rv2", rv2, 1'b0);
    chk("rst.rd1", rd1, 32'h0);  chk("rst.re2", re2, 1'b0);
    chk("rst.id1", id1, 1'b0);   chk("rst.id2", id2, 1'b0);
    reset = 1'b0;
    wait_clear("clr0");

    // Junk then re-clear
    do_req("junk_sw", 1'b1, 3'b010, 7'h3C, 32'hCAFEBABE, 32'h0, 1'b0);
    do_req("junk_lw", 1'b0, 3'b010, 7'h3C, 32'h0, 32'hCAFEBABE, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2.rdy1", rdy1, 1'b0); chk("rst2.rdy2", rdy2, 1'b0);
    reset = 1'b0;
    wait_clear("clr1");
    do_req("clr_lw", 1'b0, 3'b010, 7'h3C, 32'h0, 32'h0, 1'b0);

    // Widths
    do_req("sw10", 1'b1, 3'b010, 7'h10, 32'h80FF7F01, 32'h0, 1'b0);
    do_req("lb10",  1'b0, 3'b000, 7'h10, 32'h0, 32'h00000001, 1'b0);
    do_req("lb11",  1'b0, 3'b000, 7'h11, 32'h0, 32'h0000007F, 1'b0);
    do_req("lb12",  1'b0, 3'b000, 7'h12, 32'h0, 32'hFFFFFFFF, 1'b0);
    do_req("lbu12", 1'b0, 3'b100, 7'h12, 32'h0, 32'h000000FF, 1'b0);
    do_req("lh12",  1'b0, 3'b001, 7'h12, 32'h0, 32'hFFFF80FF, 1'b0);
    do_req("lhu12", 1'b0, 3'b101, 7'h12, 32'h0, 32'h000080FF, 1'b0);
    do_req("lbu13", 1'b0, 3'b100, 7'h13, 32'h0, 32'h00000080, 1'b0);

    // Byte lanes
    do_req("sb11",  1'b1, 3'b000, 7'h11, 32'h000000AA, 32'h0, 1'b0);
    do_req("lw_sb", 1'b0, 3'b010, 7'h10, 32'h0, 32'h80FFAA01, 1'b0);
    do_req("sh12",  1'b1, 3'b001, 7'h12, 32'h00001234, 32'h0, 1'b0);
    do_req("lw_sh", 1'b0, 3'b010, 7'h10, 32'h0, 32'h1234AA01, 1'b0);

    // Misalignment and illegal funct3
    do_req("sw20",   1'b1, 3'b010, 7'h20, 32'h11223344, 32'h0, 1'b0);
    do_req("sw22",   1'b1, 3'b010, 7'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("sh21",   1'b1, 3'b001, 7'h21, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("sbu20",  1'b1, 3'b100, 7'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
    do_req("lw20",   1'b0, 3'b010, 7'h20, 32'h0, 32'h11223344, 1'b0);
    do_req("lh13",   1'b0, 3'b001, 7'h13, 32'h0, 32'h0, 1'b1);
    do_req("lw11",   1'b0, 3'b010, 7'h11, 32'h0, 32'h0, 1'b1);
    do_req("ld011",  1'b0, 3'b011, 7'h10, 32'h0, 32'h0, 1'b1);

    // Back-to-back store then load (u2 at 0x40; u1 aliases to 0x00)
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 7'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;                          // edge N
    chk("b2b.v1_sw", rv1, 1'b1); chk("b2b.d1_sw", rd1, 32'h0);
    chk("b2b.v2_n", rv2, 1'b0);
    req_write = 1'b0;
    @(posedge clk); #1;                          // edge N+1
    req_valid = 1'b0;
    chk("b2b.v2_sw", rv2, 1'b1); chk("b2b.d2_sw", rd2, 32'h0); chk("b2b.e2_sw", re2, 1'b0);
    chk("b2b.v1_lw", rv1, 1'b1); chk("b2b.d1_lw", rd1, 32'hDEADBEEF);
    @(posedge clk); #1;                          // edge N+2
    chk("b2b.v2_lw", rv2, 1'b1); chk("b2b.d2_lw", rd2, 32'hDEADBEEF);
    chk("b2b.v1_idle", rv1, 1'b0);
    @(posedge clk); #1;
    chk("b2b.v2_idle", rv2, 1'b0);

    // Reset mid-flight
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 7'h10;
    @(posedge clk); #1;                          // load accepted
    req_valid = 1'b0; reset = 1'b1;
    chk("mid.v2_a", rv2, 1'b0);
    @(posedge clk); #1;                          // reset edge
    chk("mid.v2_b", rv2, 1'b0); chk("mid.v1", rv1, 1'b0);
    chk("mid.rdy1", rdy1, 1'b0); chk("mid.rdy2", rdy2, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid.v2_c", rv2, 1'b0);
    chk("mid.rdy1b", rdy1, 1'b0); chk("mid.rdy2b", rdy2, 1'b0);
    for (int i = 2; i <= 34; i++) begin
      @(posedge clk); #1;
      chk("mid.rdy1c", rdy1, i >= 16);
      chk("mid.rdy2c", rdy2, i >= 32);
      chk("mid.v2_d", rv2, 1'b0);
    end
    do_req("mid_lw", 1'b0, 3'b010, 7'h10, 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_sync.md
# dmem_sync

Parametrised, synchronous-read successor to the data memory of the single-cycle datapath, intended for the pipelined core's MEM stage. It accepts one load or store per cycle over a valid/ready request channel and returns exactly one response per accepted request after a fixed, parameter-selected latency. Storage is word-organised with per-byte write lanes, and an optional sweep FSM zeroes the array after reset. Misaligned or illegal-funct3 accesses are flagged, and the memory is left unchanged.

## Interface
- ADDR_WIDTH, 12: byte-address width. Depth is DEPTH = 2^(ADDR_WIDTH-2) 32-bit words.
- READ_LATENCY, 1: accept-to-response cycles. Legal values are 1 or 2.
- CLEAR_ON_RESET, 1: 1 zeroes every word after reset via a sweep; 0 leaves contents untouched.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_data  out  32  load result, extended per funct3. 0 for stores and errors.
- rsp_err  out  1  access was misaligned or had an illegal funct3.
- init_done  out  1  high once the post-reset clear (if any) is complete.

## Operation
- **FSM states:** CLEAR and RUN.
  - Reset forces CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
  - In CLEAR, the word counter runs 0..DEPTH-1 and writes 0 to one word per cycle. After the write of word DEPTH-1 the FSM moves to RUN.
- **Handshake:** req_ready = (state==RUN). A request is accepted on a cycle where req_valid && req_ready. No response back-pressure: the consumer always accepts rsp_valid.
- **Address split:** word index = req_addr[ADDR_WIDTH-1:2], byte offset = req_addr[1:0].
- **Legality:**
  - Loads: 000 LB, 100 LBU (any offset); 001 LH, 101 LHU (offset[0]=0); 010 LW (offset=0).
  - Stores: 000 SB, 001 SH, 010 SW, with the same alignment rules.
  - Anything else is an error. An error produces rsp_err=1 and rsp_data=0, with no array write.
- **Stores:**
  - Byte-lane enables are derived from funct3 and offset: SB lane = offset; SH lanes = offset, offset+1; SW lanes = all four.
  - Write data is replicated into the lanes, e.g. SB at offset 2 writes req_wdata[7:0] into bits [23:16].
  - The array is written at the accept edge.
- **Loads:**
  - The word is read at the accept edge.
  - The lane is selected by offset; LB/LH sign-extend, LBU/LHU zero-extend.
- **Response:** every accepted request yields one response carrying rsp_err and rsp_data. Stores respond with rsp_data=0.

## Timing
- **Reset values:** req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0. The response pipeline is flushed.
- **Reset with CLEAR_ON_RESET=1:** the first cycle after reset deasserts is clear cycle 0. req_ready and init_done go 1 after DEPTH clear cycles (DEPTH=1024 by default).
- **Reset with CLEAR_ON_RESET=0:** req_ready and init_done go 1 on the first cycle after reset deasserts.
- **Reset asserted mid-sweep:** the counter restarts at 0.
- **Reset asserted with responses in flight:** those responses are dropped, and rsp_valid is 0 in the following cycle.
- **Latency:** a request accepted at edge N gives rsp_valid high for the cycle following edge N+READ_LATENCY-1.
  - READ_LATENCY=1: response visible in the cycle right after acceptance.
  - READ_LATENCY=2: one additional output register stage.
- **Throughput:** one request per cycle, back-to-back, with responses in acceptance order.
- **Ordering:** a store accepted at edge N is visible to a load accepted at edge N+1 or later.
- **Single request port:** read and write never collide in the same cycle.
- **Errored accesses:** these occupy a pipeline slot exactly like legal ones.

## Test plan
- **Reset clear (CLEAR_ON_RESET=1, ADDR_WIDTH=6):**
  - Pre-load junk, pulse reset. req_ready stays 0 for 16 cycles, then goes 1.
  - LW at 0x3C then returns 0x00000000.
- **Store/load widths:**
  - SW 0x80FF7F01 to 0x10.
  - LB 0x10 -> 0x00000001. LB 0x11 -> 0x0000007F. LB 0x12 -> 0xFFFFFFFF. LBU 0x12 -> 0x000000FF.
  - LH 0x12 -> 0xFFFF80FF. LHU 0x12 -> 0x000080FF.
- **Byte lanes:** after the SW above, SB 0xAA to 0x11 then LW 0x10 -> 0x80FFAA01. SH 0x1234 to 0x12 then LW 0x10 -> 0x1234AA01.
- **Misalignment and illegal funct3:**
  - SW to 0x22 -> rsp_err=1, and a subsequent LW 0x20 is unchanged.
  - LH 0x13 -> rsp_err=1, rsp_data=0.
  - Load funct3=011 -> rsp_err=1.
- **Back-to-back with READ_LATENCY=2:** SW 0xDEADBEEF at 0x40 on cycle N, LW 0x40 on cycle N+1. The response for the load arrives on cycle N+3 with data 0xDEADBEEF, and rsp_valid is high on cycles N+2 and N+3.
- **Reset mid-flight:** LW accepted, reset asserted on the next edge. No rsp_valid appears, and req_ready=0 during the restarted clear.
